// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: FSM sequencing, registered NZCV flags, conditional execution.
// Optional retired-instruction counter enabled by defining MCCTRL_RETIRE_CNT_EN.
module multicycle_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:12]     Instr,
    input  logic [3:0]       ALUFlags,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic [3:0]       ALUControl,
    output logic [3:0]       Flags,
    output logic [3:0]       State
`ifdef MCCTRL_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] InstrCount
`endif
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9
    } state_e;

    localparam logic [3:0] AluAdd   = 4'b0000;
    localparam logic [3:0] AluSub   = 4'b0001;
    localparam logic [3:0] AluAnd   = 4'b0010;
    localparam logic [3:0] AluOrr   = 4'b0011;
    localparam logic [3:0] AluEor   = 4'b0100;
    localparam logic [3:0] AluPassB = 4'b0101;

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;

    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic [5:0] funct;
    logic       cond_ex, is_cmp, s_bit, rd_pc, wb_en, in_exec, cv_cmd;
    logic [3:0] alu_dec;
    logic       unused_rn;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign rd        = Instr[15:12];
    assign unused_rn = ^Instr[19:16];
    assign cmd       = funct[4:1];
    assign s_bit     = funct[0];
    assign is_cmp    = (cmd == 4'b1010);
    assign rd_pc     = (rd == 4'hF);
    assign cv_cmd    = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;
    assign in_exec   = (state_q == StExecR) || (state_q == StExecI);

    assign ImmSrc    = op;
    assign RegSrc    = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
    assign Flags     = flags_q;
    assign State     = state_q;

    // Condition evaluated against the registered flags, never the live ALU flags.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        alu_dec = AluAdd;
        if (op == 2'b00) begin
            case (cmd)
                4'b0100: alu_dec = AluAdd;
                4'b0010: alu_dec = AluSub;
                4'b1010: alu_dec = AluSub;
                4'b0000: alu_dec = AluAnd;
                4'b1100: alu_dec = AluOrr;
                4'b0001: alu_dec = AluEor;
                4'b1101: alu_dec = AluPassB;
                default: alu_dec = AluAdd;
            endcase
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (in_exec && cond_ex && (s_bit || is_cmp)) begin
            flags_d[3:2] = ALUFlags[3:2];
            if (cv_cmd) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_comb begin
        state_d    = StFetch;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = AluAdd;
        wb_en      = 1'b0;
        case (state_q)
            StFetch: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                state_d   = MemReady ? StDecode : StFetch;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b01:   state_d = StMemAdr;
                    2'b00:   state_d = funct[5] ? StExecI : StExecR;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                ALUSrcB = 2'b01;
                state_d = funct[0] ? StMemRd : StMemWr;
            end
            StMemRd: begin
                AdrSrc  = 1'b1;
                state_d = MemReady ? StMemWb : StMemRd;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex;
                PCWrite   = cond_ex & rd_pc;
            end
            StMemWr: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex;
                state_d  = MemReady ? StFetch : StMemWr;
            end
            StExecR: begin
                ALUControl = alu_dec;
                state_d    = StAluWb;
            end
            StExecI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
                state_d    = StAluWb;
            end
            StAluWb: begin
                wb_en    = cond_ex & ~is_cmp;
                RegWrite = wb_en;
                PCWrite  = wb_en & rd_pc;
            end
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

`ifdef MCCTRL_RETIRE_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] count_q;

    // Retire on the edge that ends the instruction; failed-condition instructions still count.
    assign retire = (state_q == StMemWb) || (state_q == StAluWb) || (state_q == StBranch) ||
                    ((state_q == StMemWr) && MemReady);
    assign InstrCount = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else if (retire) count_q <= count_q + 1'b1;
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed test-plan cases plus randomized
// instructions checked against a per-instruction path model.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [3:0]  ALUControl, Flags, State;
`ifdef MCCTRL_RETIRE_CNT_EN
    logic [31:0] InstrCount;
`endif

    multicycle_controller #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .Flags      (Flags),
        .State      (State)
`ifdef MCCTRL_RETIRE_CNT_EN
        ,
        .InstrCount (InstrCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int   st;
        logic mr;
    } step_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        mn, mz, mc, mv;
    int unsigned m_count;
    logic        af_fix_en;
    logic [3:0]  af_fix;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic cond_holds(input logic [3:0] cond, input logic n, input logic z,
                                        input logic c, input logic v);
        case (cond)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return c;
            4'd3:    return !c;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return c && !z;
            4'd9:    return !c || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 4'd0;
            4'b0010: return 4'd1;
            4'b1010: return 4'd1;
            4'b0000: return 4'd2;
            4'b1100: return 4'd3;
            4'b0001: return 4'd4;
            4'b1101: return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

    // Packed as {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,ImmSrc,RegSrc}
    function automatic logic [17:0] expect_outs(input int st, input logic mr, input logic cx,
                                                input logic [19:0] ins);
        logic [1:0] op;
        logic [5:0] funct;
        logic       pcw, adr, irw, memw, regw, asa;
        logic [1:0] asb, rsrc, rs;
        logic [3:0] aluc;
        op    = ins[15:14];
        funct = ins[13:8];
        pcw = 0; adr = 0; irw = 0; memw = 0; regw = 0; asa = 0;
        asb = 2'b00; rsrc = 2'b00; aluc = 4'd0;
        rs  = {(op == 2'b01) && !funct[0], op == 2'b10};
        case (st)
            0: begin asa = 1; asb = 2'b10; rsrc = 2'b10; irw = mr; pcw = mr; end
            1: begin asa = 1; asb = 2'b10; rsrc = 2'b10; end
            2: asb = 2'b01;
            3: adr = 1;
            4: begin rsrc = 2'b01; regw = cx; pcw = cx && (ins[3:0] == 4'hF); end
            5: begin adr = 1; memw = cx; end
            6: aluc = alu_of(funct[4:1]);
            7: begin asb = 2'b01; aluc = alu_of(funct[4:1]); end
            8: begin
                regw = cx && (funct[4:1] != 4'b1010);
                pcw  = regw && (ins[3:0] == 4'hF);
            end
            9: begin asb = 2'b01; rsrc = 2'b10; pcw = cx; end
            default: ;
        endcase
        return {pcw, adr, irw, memw, regw, asa, asb, rsrc, aluc, op, rs};
    endfunction

    // Runs one instruction; wf/wm are MemReady=0 cycles in fetch and memory access.
    // abort_at >= 0 asserts reset asynchronously in that step of the path.
    task automatic run_instr(input logic [31:0] word, input int wf, input int wm,
                             input int abort_at);
        logic [19:0] ins;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic        cx;
        step_t       path[$];
        ins   = word[31:12];
        op    = ins[15:14];
        funct = ins[13:8];
        for (int k = 0; k < wf; k++) path.push_back('{0, 1'b0});
        path.push_back('{0, 1'b1});
        path.push_back('{1, 1'($urandom)});
        case (op)
            2'b01: begin
                path.push_back('{2, 1'($urandom)});
                if (funct[0]) begin
                    for (int k = 0; k < wm; k++) path.push_back('{3, 1'b0});
                    path.push_back('{3, 1'b1});
                    path.push_back('{4, 1'($urandom)});
                end else begin
                    for (int k = 0; k < wm; k++) path.push_back('{5, 1'b0});
                    path.push_back('{5, 1'b1});
                end
            end
            2'b00: begin
                path.push_back('{funct[5] ? 7 : 6, 1'($urandom)});
                path.push_back('{8, 1'($urandom)});
            end
            2'b10:   path.push_back('{9, 1'($urandom)});
            default: ;
        endcase

        for (int i = 0; i < path.size(); i++) begin
            @(negedge clk);
            Instr    = ins;
            MemReady = path[i].mr;
            ALUFlags = af_fix_en ? af_fix : 4'($urandom);
            #1;
            cx = cond_holds(ins[19:16], mn, mz, mc, mv);
            check($sformatf("state[%0d] %h", i, word), 32'(State), path[i].st);
            check($sformatf("flags[%0d] %h", i, word), 32'(Flags), 32'({mn, mz, mc, mv}));
            check($sformatf("outs st%0d %h", path[i].st, word),
                  32'({PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA, ALUSrcB,
                       ResultSrc, ALUControl, ImmSrc, RegSrc}),
                  32'(expect_outs(path[i].st, path[i].mr, cx, ins)));
`ifdef MCCTRL_RETIRE_CNT_EN
            check($sformatf("count[%0d] %h", i, word), InstrCount, m_count);
`endif
            if (i == abort_at) begin
                #2;
                reset    = 1'b0;
                MemReady = 1'b1;
                #1;
                check("rst state", 32'(State), 0);
                check("rst flags", 32'(Flags), 0);
                check("rst irw/pcw/regw/memw", 32'({IRWrite, PCWrite, RegWrite, MemWrite}),
                      32'(4'b1100));
`ifdef MCCTRL_RETIRE_CNT_EN
                check("rst count", InstrCount, 0);
`endif
                {mn, mz, mc, mv} = 4'b0000;
                m_count = 0;
                @(posedge clk);
                #1;
                check("rst hold state", 32'(State), 0);
                @(negedge clk);
                MemReady = 1'b0;
                reset    = 1'b1;
                return;
            end
            // Effects that land on the edge closing this step.
            if ((path[i].st == 6 || path[i].st == 7) && cx &&
                (funct[0] || funct[4:1] == 4'b1010)) begin
                mn = ALUFlags[3];
                mz = ALUFlags[2];
                if (funct[4:1] == 4'b0100 || funct[4:1] == 4'b0010 || funct[4:1] == 4'b1010) begin
                    mc = ALUFlags[1];
                    mv = ALUFlags[0];
                end
            end
            if (i == path.size() - 1 && op != 2'b11) m_count++;
        end
    endtask

    initial begin
        logic [31:0] w;
        reset     = 1'b0;
        Instr     = '0;
        ALUFlags  = '0;
        MemReady  = 1'b1;
        af_fix_en = 1'b0;
        af_fix    = '0;
        {mn, mz, mc, mv} = 4'b0000;
        m_count   = 0;
        #1;
        check("reset state", 32'(State), 0);
        check("reset irw/pcw", 32'({IRWrite, PCWrite, RegWrite, MemWrite}), 32'(4'b1100));
        repeat (2) @(posedge clk);
        @(negedge clk);
        MemReady = 1'b0;
        reset    = 1'b1;

        run_instr(32'hE2811005, 0, 0, -1);  // ADD imm
        af_fix_en = 1'b1;
        af_fix    = 4'b0100;
        run_instr(32'hE3500000, 1, 0, -1);  // CMP -> Z
        af_fix_en = 1'b0;
        run_instr(32'h0A000002, 0, 0, -1);  // BEQ taken
        af_fix_en = 1'b1;
        af_fix    = 4'b0000;
        run_instr(32'hE3500000, 0, 0, -1);  // CMP -> clear
        af_fix_en = 1'b0;
        run_instr(32'h0A000002, 0, 0, -1);  // BEQ not taken
        run_instr(32'hE5912000, 0, 2, -1);  // LDR with 2 wait cycles
        run_instr(32'h0581F000, 0, 1, -1);  // STR, condition fails
        run_instr(32'hE1A0F00E, 0, 0, -1);  // MOV PC, LR
        af_fix_en = 1'b1;
        af_fix    = 4'b1011;
        run_instr(32'hE3500000, 0, 0, -1);  // CMP -> nonzero flags before reset
        af_fix_en = 1'b0;
        run_instr(32'hE5912000, 0, 3, 4);   // reset mid-MEMRD wait

        for (int n = 0; n < 300; n++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 0) w[31:28] = 4'hE;
            run_instr(w, $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
